score_scan: RTL
===============

SCORE_SCAN -- requirements
Module: score_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000, the number of clk cycles each digit is displayed (legal range 2..2^20).
REQ-002 The module SHALL have port clk, input, 1 bit, the single rising-edge clock for all state.
REQ-003 The module SHALL have port reset, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The module SHALL have port clear, input, 1 bit, a synchronous score clear (new game).
REQ-005 The module SHALL have port add_valid, input, 1 bit, a request to add points for a line-clear event.
REQ-006 The module SHALL have port add_lines, input, 3 bits, the number of lines cleared.
REQ-007 The module SHALL have port add_ready, output, 1 bit, high when an add request can be accepted.
REQ-008 The module SHALL have port score_bcd, output, 16 bits, the committed score as 4 BCD digits, [3:0] being the ones digit.
REQ-009 The module SHALL have port num, output, 4 bits, the BCD digit currently scanned (feeds the 7-segment decoder).
REQ-010 The module SHALL have port digit_sel, output, 4 bits, a one-hot active-high enable for the scanned digit, bit0 being ones.
REQ-011 The module SHALL have port blank, output, 1 bit, high when the scanned digit is a leading zero and must be dark.

Function
REQ-012 The add-request handshake SHALL complete on a rising edge with add_valid=1, add_ready=1 and clear=0; add_lines SHALL be sampled on that edge only.
REQ-013 The points added SHALL be: 0 lines -> 0, 1 -> 1, 2 -> 3, 3 -> 5, 4 -> 8, and 5..7 -> 8.
REQ-014 The adder FSM SHALL have states IDLE, ADD and COMMIT; add_ready SHALL be 1 only in IDLE.
REQ-015 On the accepting edge, IDLE->ADD SHALL occur, loading a working copy from score_bcd, resetting the digit index to 0 and clearing the carry.
REQ-016 In ADD, each edge SHALL process one digit: work[d] = work[d] + addend digit + carry; a sum >9 SHALL subtract 10 and set carry; d increments.
REQ-017 After digit 3 is processed, ADD->COMMIT SHALL occur, so ADD lasts exactly 4 cycles.
REQ-018 On the COMMIT edge, score_bcd SHALL take the working value, or 16'h9999 if the digit-3 carry is set (saturation), and the FSM SHALL go ->IDLE.
REQ-019 score_bcd SHALL update exactly 5 edges after the accepting edge, and add_ready SHALL be high from that edge onward.
REQ-020 score_bcd SHALL never show a partial sum.
REQ-021 A 0-point request SHALL take the same 5-edge path, leaving score_bcd unchanged.
REQ-022 clear=1 SHALL have the highest priority: score_bcd<=0, the FSM ->IDLE, any in-flight addition SHALL be discarded, and add_valid SHALL be ignored that edge.
REQ-023 The scan prescaler SHALL count 0..SCAN_DIV-1 and wrap.
REQ-024 On each wrap, the scan digit index SHALL advance 0->1->2->3->0.
REQ-025 The prescaler and scan digit index SHALL be unaffected by clear and by the adder FSM.
REQ-026 digit_sel SHALL equal 1 << index.
REQ-027 num SHALL equal score_bcd digit[index], combinationally from the registered score and index.
REQ-028 blank SHALL be 1 iff index>0 and score_bcd digits index..3 are all zero; the ones digit SHALL never be blanked.

Reset
REQ-029 While reset=1, asynchronously: score_bcd=0, FSM=IDLE, add_ready=1, the working copy, carry, digit index and prescaler SHALL be 0, digit_sel=4'b0001, num=0 and blank=0.
REQ-030 reset asserted mid-addition SHALL abort it with no commit.
REQ-031 After reset deasserts, the first request SHALL be acceptable on the first edge.

Verification (bench SCAN_DIV=4)
REQ-032 Reset, then add_lines=4 accepted: add_ready low for 5 edges; score_bcd 0000->0008 on edge 5; add_ready=1.
REQ-033 Score 0095, add_lines=3: carry ripples through two digits; score_bcd=0100; no intermediate score_bcd value is observed.
REQ-034 Score 9995, add_lines=4: score_bcd=9999 (saturated); a further add_lines=1 keeps 9999.
REQ-035 Score 0042, clear asserted 2 edges into ADD: score_bcd=0000 next edge; FSM IDLE; add_ready=1; no later commit.
REQ-036 Score 0100, scan run 16 cycles: digit_sel 0001,0010,0100,1000 each for 4 cycles; num 0,0,1,0; blank 0,0,0,1.
REQ-037 reset pulsed mid-ADD: all outputs are at reset values immediately (before the next edge); subsequent add_lines=2 gives score_bcd=0003.

Source files
------------

// File: rtl/score_scan.sv
// score_scan: BCD score accumulator with serial digit adder and multiplexed 7-segment scan outputs.
module score_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_valid,
  input  logic [2:0]  add_lines,
  output logic        add_ready,
  output logic [15:0] score_bcd,
  output logic [3:0]  num,
  output logic [3:0]  digit_sel,
  output logic        blank
);
  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
  state_t state, state_n;
  logic [15:0] work;
  logic        carry;
  logic [1:0]  d;
  logic [3:0]  pts, pts_n, dig;
  logic [4:0]  sum;
  logic [19:0] cnt;
  logic [1:0]  idx;
  assign pts_n = add_lines == 3'd0 ? 4'd0 : add_lines == 3'd1 ? 4'd1 : add_lines == 3'd2 ? 4'd3 :
                 add_lines == 3'd3 ? 4'd5 : 4'd8;
  // Only the ones digit of the addend is nonzero; higher digits just ripple the carry.
  assign sum = 5'(work[{d, 2'b00} +: 4]) + 5'(d == 2'd0 ? pts : 4'd0) + 5'(carry);
  assign dig = 4'(sum > 5'd9 ? sum - 5'd10 : sum);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = clear ? IDLE : state == IDLE ? (add_valid ? ADD : IDLE) :
              state == ADD ? (d == 2'd3 ? COMMIT : ADD) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      score_bcd <= '0;
      work <= '0;
      carry <= 1'b0;
      d <= '0;
      pts <= '0;
    end else if (clear) score_bcd <= '0;
    else if (state == IDLE && add_valid) begin
      work <= score_bcd;
      d <= '0;
      carry <= 1'b0;
      pts <= pts_n;
    end else if (state == ADD) begin
      work[{d, 2'b00} +: 4] <= dig;
      carry <= sum > 5'd9;
      d <= d + 2'd1;
    end else if (state == COMMIT) score_bcd <= carry ? 16'h9999 : work;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == 20'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else cnt <= cnt + 20'd1;
  always_comb begin
    add_ready = state == IDLE;
    digit_sel = 4'b0001 << idx;
    num = score_bcd[{idx, 2'b00} +: 4];
    blank = idx == 2'd3 ? score_bcd[15:12] == 4'd0 : idx == 2'd2 ? score_bcd[15:8] == 8'd0 :
            idx == 2'd1 ? score_bcd[15:4] == 12'd0 : 1'b0;
  end
endmodule
